// File: rtl/priority_encoder.sv
// priority_encoder
//   Registered 4-to-2 priority encoder. D[3] has the highest priority. The
//   encoded index, a valid flag and the one-hot form of the winning request
//   are captured on an enabled rising edge. All outputs come straight from
//   flops, so there is no combinational path from any input to any output.
//
// Ports
//   clk    : rising-edge clock for all state
//   rst    : synchronous active-high reset, takes priority over en
//   en     : capture enable for the output registers
//   D      : request vector, D[3] highest priority
//   Y      : binary index of the highest set bit of the captured D
//   valid  : 1 when the captured D was nonzero
//   onehot : one-hot form of the winning bit, 0000 when not valid
module priority_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] D,
  output logic [1:0] Y,
  output logic       valid,
  output logic [3:0] onehot
);

  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic [3:0] onehot_q, onehot_d;

  logic [1:0] enc_y;
  logic       enc_valid;
  logic [3:0] enc_onehot;

  // Higher bits mask everything below them. D=0000 also encodes to 00;
  // enc_valid is the only thing that tells it apart from D=0001.
  always_comb begin
    enc_y      = 2'b00;
    enc_onehot = 4'b0000;
    casez (D)
      4'b1???: begin enc_y = 2'b11; enc_onehot = 4'b1000; end
      4'b01??: begin enc_y = 2'b10; enc_onehot = 4'b0100; end
      4'b001?: begin enc_y = 2'b01; enc_onehot = 4'b0010; end
      4'b0001: begin enc_y = 2'b00; enc_onehot = 4'b0001; end
      default: begin enc_y = 2'b00; enc_onehot = 4'b0000; end
    endcase
    enc_valid = |D;
  end

  // Without en the registers simply recirculate their current value.
  always_comb begin
    y_d      = y_q;
    valid_d  = valid_q;
    onehot_d = onehot_q;
    if (en) begin
      y_d      = enc_y;
      valid_d  = enc_valid;
      onehot_d = enc_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= 2'b00;
      valid_q  <= 1'b0;
      onehot_q <= 4'b0000;
    end else begin
      y_q      <= y_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

  assign Y      = y_q;
  assign valid  = valid_q;
  assign onehot = onehot_q;

endmodule

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] D   = 4'b0000;
  logic [1:0] Y;
  logic       valid;
  logic [3:0] onehot;

  int checks   = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [6:0] outs;   // {Y, valid, onehot}
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference state of the output registers.
  logic [1:0] m_y  = 2'b00;
  logic       m_v  = 1'b0;
  logic [3:0] m_oh = 4'b0000;

  priority_encoder dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .D      (D),
    .Y      (Y),
    .valid  (valid),
    .onehot (onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed Y/valid/onehot=%b/%b/%b expected %b/%b/%b",
                tag, obs[6:5], obs[4], obs[3:0], expv[6:5], expv[4], expv[3:0]);
  endtask

  // Scans upward so the last set bit seen (the highest) wins.
  task automatic model_edge(input logic r, input logic e, input logic [3:0] d);
    logic [1:0] idx;
    idx = 2'b00;
    for (int i = 0; i < 4; i++)
      if (d[i] == 1'b1) idx = 2'(i);
    if (r) begin
      m_y = 2'b00; m_v = 1'b0; m_oh = 4'b0000;
    end else if (e) begin
      m_y  = idx;
      m_v  = (d != 4'b0000);
      m_oh = m_v ? (4'b0001 << idx) : 4'b0000;
    end
  endtask

  // Drive on the falling edge, predict, then compare 1 time unit after the
  // rising edge that captures the values.
  task automatic step(input logic r, input logic e, input logic [3:0] d, input string tag);
    exp_t ent;
    @(negedge clk);
    rst = r; en = e; D = d;
    model_edge(r, e, d);
    ent.outs = {m_y, m_v, m_oh};
    ent.tag  = tag;
    exp_q.push_back(ent);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      ent = exp_q.pop_front();
      check(ent.tag, {Y, valid, onehot}, ent.outs);
    end
  endtask

  initial begin
    // Reset held for two edges.
    step(1'b1, 1'b0, 4'b1010, "reset_edge1");
    step(1'b1, 1'b1, 4'b1111, "reset_edge2");

    // Basic priority patterns.
    step(1'b0, 1'b1, 4'b1000, "d_1000");
    step(1'b0, 1'b1, 4'b1111, "d_1111");
    step(1'b0, 1'b1, 4'b0111, "d_0111");
    step(1'b0, 1'b1, 4'b0001, "d_0001");
    step(1'b0, 1'b1, 4'b0000, "d_0000");

    // Capture then hold with en low while D changes.
    step(1'b0, 1'b1, 4'b0110, "cap_0110");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'b1000, $sformatf("hold_%0d", i));

    // Reset wins over en on the same edge, then capture resumes at once.
    step(1'b1, 1'b1, 4'b1000, "rst_over_en");
    step(1'b0, 1'b1, 4'b1000, "post_rst_cap");

    // D and rst changing between edges must not reach the outputs.
    step(1'b0, 1'b1, 4'b0100, "cap_0100");
    D = 4'b1000;
    #2;
    check("mid_cycle_d", {Y, valid, onehot}, {m_y, m_v, m_oh});
    rst = 1'b1;
    #1;
    check("mid_cycle_rst", {Y, valid, onehot}, {m_y, m_v, m_oh});
    step(1'b1, 1'b1, 4'b1000, "rst_edge");

    // Exhaustive sweep.
    for (int v = 0; v < 16; v++)
      step(1'b0, 1'b1, 4'(v), $sformatf("sweep_%0d", v));

    // A few random patterns mixing en.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $sformatf("rand_%0d", i));

    if (exp_q.size() != 0) begin
      checks++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
Parameters: none; all widths are fixed as stated below.
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port en, input, 1 bit: capture enable for the output registers.
REQ-005 SHALL have port D, input, 4 bits: request vector; D[3] has the highest priority.
REQ-006 SHALL have port Y, output, 2 bits: registered binary index of the highest set bit of D.
REQ-007 SHALL have port valid, output, 1 bit: registered flag, 1 when the captured D was nonzero.
REQ-008 SHALL have port onehot, output, 4 bits: registered one-hot form of the winning bit (0000 when not valid).
REQ-009 SHALL drive all outputs directly from flip-flops, with no combinational path from inputs to outputs.

Function
REQ-010 SHALL compute the next Y by strict priority:
- D[3]=1 -> 11
- else D[2]=1 -> 10
- else D[1]=1 -> 01
- else D[0]=1 -> 00
- D=0000 -> 00
REQ-011 SHALL ignore every bit below the highest set bit, so 1111 and 1000 both give Y=11.
REQ-012 SHALL set the next valid to the OR of D[3:0].
REQ-013 SHALL set the next onehot to 1 << Y when valid=1, and to 0000 when D=0000.
REQ-014 SHALL capture the next Y, valid and onehot at a rising clk edge when en=1 and rst=0.
- Latency is exactly 1 cycle from D to outputs.
REQ-015 SHALL hold Y, valid and onehot unchanged at a rising edge when en=0 and rst=0.
REQ-016 SHALL keep outputs stable between clock edges; changes on D between edges SHALL have no effect until the next enabled edge.
REQ-017 SHALL NOT distinguish "D=0000" from "D=0001" on Y alone; consumers SHALL use valid to tell them apart.
REQ-018 SHALL treat X/Z on D as don't-care; outputs are unspecified for the following cycle only.

Reset
REQ-019 SHALL set Y=00, valid=0 and onehot=0000 on a rising clk edge with rst=1.
REQ-020 SHALL give rst priority over en.
REQ-021 SHALL NOT clear the outputs asynchronously; when rst rises between edges, outputs SHALL hold until the next edge.
REQ-022 SHALL resume normal capture on the first rising edge with rst=0 and en=1, with no extra latency after reset.
REQ-023 SHALL give all outputs their reset values from the first edge with rst=1; outputs are undefined before any reset edge.

Verification
REQ-024 SHALL pass the bench scenario: rst=1 for 2 edges -> Y=00, valid=0, onehot=0000.
REQ-025 SHALL pass the bench scenario: en=1, D applied one per cycle as 1000, 1111, 0111, 0001 -> one cycle later Y=11, 11, 10, 00 and valid=1 each time; onehot=1000, 1000, 0100, 0001.
REQ-026 SHALL pass the bench scenario: en=1, D=0000 -> next cycle Y=00, valid=0, onehot=0000.
REQ-027 SHALL pass the bench scenario: capture D=0110 (Y=10), then en=0 and D=1000 for 3 edges -> Y stays 10 and valid stays 1.
REQ-028 SHALL pass the bench scenario: en=1, D=1000, rst=1 on the same edge -> Y=00, valid=0; rst=0 on the next edge -> Y=11.
REQ-029 SHALL pass the bench scenario: exhaustive sweep of all 16 D values with en=1 -> each output matches REQ-010 to REQ-013 one cycle after that value is applied.
